// File: rtl/qsys_cpu_oci_dct_packer.sv
// Direct-call-trace packer: shifts 2-bit trace codes into a live accumulator and hands
// full or flushed groups to a one-entry ready/valid packet register; also sequences end-of-test.
module qsys_cpu_oci_dct_packer #(
    parameter int ENTRY_W = 2,
    parameter int DEPTH   = 15,
    parameter int BUF_W   = ENTRY_W * DEPTH,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trc_on,
    input  logic               in_valid,
    input  logic [ENTRY_W-1:0] in_code,
    input  logic               flush_req,
    input  logic               end_req,
    input  logic               pkt_ready,
    output logic               pkt_valid,
    output logic [BUF_W-1:0]   pkt_data,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               overflow,
    output logic               test_ending,
    output logic               test_has_ended
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {RUN, ENDING, ENDED} state_t;

    state_t state, state_nxt;
    logic   slot_free, full, has_data, xfer, code_in, accept, drop, go_ended;

    assign slot_free = !pkt_valid || pkt_ready;
    assign full      = (dct_count == FULL_CNT);
    assign has_data  = (dct_count != '0);
    // flush_req only matters while running; ENDING drains unconditionally.
    assign xfer      = slot_free && has_data &&
                       (full || (flush_req && state == RUN) || state == ENDING);
    assign code_in   = trc_on && in_valid && (state == RUN);
    assign accept    = code_in && (!full || xfer);
    assign drop      = code_in && full && !xfer;

    always_comb begin
        state_nxt = state;
        go_ended  = 1'b0;
        case (state)
            RUN:     if (end_req) state_nxt = ENDING;
            ENDING:  if (!has_data && !pkt_valid) begin
                         state_nxt = ENDED;
                         go_ended  = 1'b1;
                     end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            test_ending <= 1'b0;
        end else begin
            state       <= state_nxt;
            test_ending <= go_ended;
        end
    end

    assign test_has_ended = (state == ENDED);

    // A code arriving with a transfer starts the freshly cleared accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (xfer) begin
            dct_buffer <= accept ? BUF_W'(in_code) : '0;
            dct_count  <= accept ? ONE_CNT : '0;
        end else if (accept) begin
            dct_buffer <= {dct_buffer[BUF_W-ENTRY_W-1:0], in_code};
            dct_count  <= dct_count + ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_count <= '0;
        end else if (xfer) begin
            pkt_valid <= 1'b1;
            pkt_data  <= dct_buffer;
            pkt_count <= dct_count;
        end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_qsys_cpu_oci_dct_packer.sv
// Bench for the DCT packer: directed scenarios plus randomized traffic against a queue-based model.
module tb_qsys_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0, trc_on = 1'b0, in_valid = 1'b0, flush_req = 1'b0;
    logic        end_req = 1'b0, pkt_ready = 1'b0;
    logic [1:0]  in_code = '0;
    logic        pkt_valid, overflow, test_ending, test_has_ended;
    logic [29:0] pkt_data, dct_buffer;
    logic [3:0]  pkt_count, dct_count;

    int total = 0;
    int bad   = 0;

    // Reference model: accumulator as a queue of codes, oldest first.
    int          m_acc[$];
    logic        m_pv = 0, m_ovf = 0, m_te = 0;
    logic [29:0] m_pd = '0;
    int          m_pc = 0;
    int          m_st = 0; // 0 running, 1 ending, 2 ended

    qsys_cpu_oci_dct_packer dut (
        .clk(clk), .reset(reset), .trc_on(trc_on), .in_valid(in_valid), .in_code(in_code),
        .flush_req(flush_req), .end_req(end_req), .pkt_ready(pkt_ready),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_count(pkt_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
        .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pack_q(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = v * 4 + q[i];
        return v[29:0];
    endfunction

    task automatic tick(input logic r, input logic t, input logic v, input logic [1:0] c,
                        input logic f, input logic e, input logic rdy);
        int   n;
        logic xf, take, old_pv;
        reset = r; trc_on = t; in_valid = v; in_code = c;
        flush_req = f; end_req = e; pkt_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_acc.delete(); m_pv = 0; m_pd = '0; m_pc = 0; m_ovf = 0; m_st = 0; m_te = 0;
        end else begin
            n      = m_acc.size();
            old_pv = m_pv;
            xf     = (!m_pv || rdy) && n > 0 && (n == 15 || (f && m_st == 0) || m_st == 1);
            take   = t && v && m_st == 0;
            m_te   = (m_st == 1 && n == 0 && !old_pv);
            if (xf) begin
                m_pd = pack_q(m_acc); m_pc = n; m_pv = 1; m_acc.delete();
            end else if (rdy) begin
                m_pv = 0;
            end
            if (take) begin
                if (m_acc.size() < 15) m_acc.push_back(int'(c));
                else m_ovf = 1;
            end
            if (m_st == 0 && e) m_st = 1;
            else if (m_te) m_st = 2;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        total++; if ({pkt_valid, pkt_data, pkt_count, dct_buffer, dct_count, overflow,
                      test_ending, test_has_ended} !== '0) begin
            bad++; $display("FAIL reset_outputs got pv=%b pd=%h pc=%0d buf=%h cnt=%0d ovf=%b te=%b the=%b want all 0",
                            pkt_valid, pkt_data, pkt_count, dct_buffer, dct_count, overflow, test_ending, test_has_ended);
        end
    endtask

    task automatic test_flush();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 2'd1, 0, 0, 1);
        tick(0, 1, 1, 2'd2, 0, 0, 1);
        tick(0, 1, 1, 2'd3, 0, 0, 1);
        total++; if (dct_buffer !== 30'h1B || dct_count !== 4'd3) begin
            bad++; $display("FAIL flush_accum got buf=%h cnt=%0d want 1b/3", dct_buffer, dct_count);
        end
        tick(0, 1, 0, 2'd0, 1, 0, 1);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h1B || pkt_count !== 4'd3) begin
            bad++; $display("FAIL flush_pkt got pv=%b pd=%h pc=%0d want 1/1b/3", pkt_valid, pkt_data, pkt_count);
        end
        total++; if (dct_count !== 4'd0) begin
            bad++; $display("FAIL flush_clear got cnt=%0d want 0", dct_count);
        end
        tick(0, 1, 0, 2'd0, 0, 0, 1);
        total++; if (pkt_valid !== 1'b0) begin
            bad++; $display("FAIL flush_drain got pv=%b want 0", pkt_valid);
        end
        tick(0, 1, 0, 2'd0, 1, 0, 1);
        total++; if (pkt_valid !== 1'b0) begin
            bad++; $display("FAIL flush_empty got pv=%b want 0", pkt_valid);
        end
    endtask

    task automatic test_auto_packet();
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick(0, 1, 1, 2'b10, 0, 0, 1);
        total++; if (dct_count !== 4'd15 || pkt_valid !== 1'b0) begin
            bad++; $display("FAIL auto_full got cnt=%0d pv=%b want 15/0", dct_count, pkt_valid);
        end
        tick(0, 1, 1, 2'b10, 0, 0, 1);
        total++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h2AAAAAAA || pkt_count !== 4'd15) begin
            bad++; $display("FAIL auto_pkt got pv=%b pd=%h pc=%0d want 1/2aaaaaaa/15", pkt_valid, pkt_data, pkt_count);
        end
        total++; if (dct_count !== 4'd1 || dct_buffer !== 30'h2 || overflow !== 1'b0) begin
            bad++; $display("FAIL auto_16th got cnt=%0d buf=%h ovf=%b want 1/2/0", dct_count, dct_buffer, overflow);
        end
    endtask

    task automatic test_backpressure();
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) tick(0, 1, 1, 2'b01, 0, 0, 0);
        total++; if (pkt_valid !== 1'b1 || pkt_count !== 4'd15 || pkt_data !== 30'h15555555) begin
            bad++; $display("FAIL bp_held got pv=%b pd=%h pc=%0d want 1/15555555/15", pkt_valid, pkt_data, pkt_count);
        end
        total++; if (dct_count !== 4'd15 || dct_buffer !== 30'h15555555 || overflow !== 1'b1) begin
            bad++; $display("FAIL bp_accum got cnt=%0d buf=%h ovf=%b want 15/15555555/1", dct_count, dct_buffer, overflow);
        end
        tick(0, 1, 0, 2'b00, 0, 0, 1);
        total++; if (pkt_valid !== 1'b1 || pkt_count !== 4'd15 || dct_count !== 4'd0) begin
            bad++; $display("FAIL bp_second got pv=%b pc=%0d cnt=%0d want 1/15/0", pkt_valid, pkt_count, dct_count);
        end
    endtask

    task automatic test_end();
        int pkts = 0, pulses = 0;
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 2'b11, 0, 0, 1);
        tick(0, 1, 0, 2'b00, 0, 1, 1);
        total++; if (dct_count !== 4'd5 || test_has_ended !== 1'b0) begin
            bad++; $display("FAIL end_start got cnt=%0d the=%b want 5/0", dct_count, test_has_ended);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 1, 2'b11, 1, 1, 1);
            if (pkt_valid) begin
                pkts++;
                total++; if (pkt_count !== 4'd5 || pkt_data !== 30'h3FF) begin
                    bad++; $display("FAIL end_pkt got pd=%h pc=%0d want 3ff/5", pkt_data, pkt_count);
                end
            end
            if (test_ending) pulses++;
            total++; if (dct_count !== 4'd0) begin
                bad++; $display("FAIL end_cnt got cnt=%0d want 0", dct_count);
            end
        end
        total++; if (pkts != 1 || pulses != 1 || test_has_ended !== 1'b1) begin
            bad++; $display("FAIL end_seq got pkts=%0d pulses=%0d the=%b want 1/1/1", pkts, pulses, test_has_ended);
        end
    endtask

    task automatic test_trc_off();
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 2'($urandom), 0, 0, 1);
        total++; if (dct_count !== 4'd0 || overflow !== 1'b0 || pkt_valid !== 1'b0) begin
            bad++; $display("FAIL trc_off got cnt=%0d ovf=%b pv=%b want 0/0/0", dct_count, overflow, pkt_valid);
        end
    endtask

    task automatic test_mid_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) tick(0, 1, 1, 2'b01, 0, 0, 0);
        tick(0, 1, 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 1, 1, 2'b10, 0, 0, 0);
        total++; if (pkt_valid !== 1'b1 || dct_count !== 4'd7 || overflow !== 1'b1) begin
            bad++; $display("FAIL mr_setup got pv=%b cnt=%0d ovf=%b want 1/7/1", pkt_valid, dct_count, overflow);
        end
        tick(1, 1, 1, 2'b10, 0, 0, 0);
        total++; if ({pkt_valid, pkt_data, pkt_count, dct_buffer, dct_count, overflow,
                      test_ending, test_has_ended} !== '0) begin
            bad++; $display("FAIL mr_outputs got pv=%b pd=%h pc=%0d buf=%h cnt=%0d ovf=%b want all 0",
                            pkt_valid, pkt_data, pkt_count, dct_buffer, dct_count, overflow);
        end
        tick(0, 1, 1, 2'b10, 0, 0, 0);
        total++; if (dct_count !== 4'd1 || dct_buffer !== 30'h2) begin
            bad++; $display("FAIL mr_after got cnt=%0d buf=%h want 1/2", dct_count, dct_buffer);
        end
    endtask

    task automatic test_random();
        logic r;
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 1500; i++) begin
            r = ($urandom_range(0, 149) == 0) || (i % 250 == 0);
            tick(r, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 119) == 0, $urandom_range(0, 2) != 0);
            total++; if (dct_count !== 4'(m_acc.size()) || dct_buffer !== pack_q(m_acc)) begin
                bad++; $display("FAIL rnd_accum cyc=%0d got buf=%h cnt=%0d want %h/%0d",
                                i, dct_buffer, dct_count, pack_q(m_acc), m_acc.size());
            end
            total++; if (pkt_valid !== m_pv || (m_pv && (pkt_data !== m_pd || pkt_count !== 4'(m_pc)))) begin
                bad++; $display("FAIL rnd_pkt cyc=%0d got pv=%b pd=%h pc=%0d want %b/%h/%0d",
                                i, pkt_valid, pkt_data, pkt_count, m_pv, m_pd, m_pc);
            end
            total++; if (overflow !== m_ovf || test_ending !== m_te || test_has_ended !== (m_st == 2)) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got ovf=%b te=%b the=%b want %b/%b/%b",
                                i, overflow, test_ending, test_has_ended, m_ovf, m_te, m_st == 2);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_flush();
        test_auto_packet();
        test_backpressure();
        test_end();
        test_trc_off();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsys_cpu_oci_dct_packer.md
# qsys_cpu_oci_dct_packer

Direct-call-trace packer for the CPU on-chip-instrumentation (OCI) trace path. It collects 2-bit trace codes into a 30-bit accumulator and exposes the live accumulator as `dct_buffer`/`dct_count`. These feed the OCI test-bench monitor directly. Completed groups are handed downstream through a one-entry ready/valid packet register, and the block generates the `test_ending`/`test_has_ended` end-of-test indications consumed by that monitor.

## Interface
Parameters
- ENTRY_W, 2: bits per trace code.
- DEPTH, 15: entries per packet; buffer width is ENTRY_W*DEPTH = 30, count width is 4.

Ports
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- trc_on  in  1  trace enable; when 0, in_valid is ignored.
- in_valid  in  1  a trace code is present this cycle.
- in_code  in  2  trace code.
- flush_req  in  1  emit a partial accumulator as a packet.
- end_req  in  1  begin the end-of-test sequence.
- pkt_ready  in  1  downstream accepts the packet.
- pkt_valid  out  1  packet register holds a packet.
- pkt_data  out  30  packed codes.
- pkt_count  out  4  valid entries in pkt_data (1..15).
- dct_buffer  out  30  live accumulator contents.
- dct_count  out  4  live accumulator entry count (0..15).
- overflow  out  1  sticky flag: a code was dropped.
- test_ending  out  1  one-cycle pulse on entry to ENDED.
- test_has_ended  out  1  level, high while in ENDED.

## Operation
- Reset: all outputs 0, accumulator cleared, state RUN.
- Packing: each accepted code updates the accumulator as dct_buffer <= {dct_buffer[27:0], in_code} and increments dct_count.
  - The newest code is at [1:0]; the oldest is at [2*count-1:2*count-2].
  - Bits above 2*count-1 are always 0.
- Slot free: slot_free = !pkt_valid || pkt_ready.
- Transfer condition: slot_free && count>0 && (count==15 || flush_req || state==ENDING).
- On transfer:
  - pkt_data <= dct_buffer; pkt_count <= dct_count; pkt_valid <= 1.
  - The accumulator clears.
  - A code accepted in the same cycle lands in the cleared accumulator, giving count 1 and buffer {28'b0, in_code}.
- Accept condition: trc_on && in_valid && state==RUN && (count<15 || transfer).
- Drop: trc_on && in_valid && state==RUN && count==15 && !transfer sets overflow <= 1. Accumulator is unchanged. overflow is cleared only by reset.
- Packet drain: pkt_valid clears when pkt_ready is high and no new transfer occurs in the same cycle.
- States:
  - RUN: end_req moves to ENDING. A code presented in the same cycle as end_req is still accepted.
  - ENDING: inputs and flush_req are ignored. The remaining accumulator is flushed per the transfer condition. When count==0 && !pkt_valid, move to ENDED.
  - ENDED: inputs, flush_req and end_req are ignored. test_has_ended = 1. Exit only via reset.
- end_req in ENDING or ENDED is ignored.
- flush_req with count==0 is a no-op.

## Timing
- A code sampled at edge N appears in dct_buffer/dct_count after edge N.
- Transfer sampled at edge N gives pkt_valid = 1 after edge N.
  - Code-to-packet latency is 1 cycle when the packet is triggered by the 15th entry: that entry lands in the accumulator at N, and the transfer fires at N+1.
- Handshake:
  - A packet is consumed on any edge where pkt_valid && pkt_ready.
  - Back-to-back packets are sustained at 1 per cycle when pkt_ready is held high.
  - pkt_data and pkt_count are stable while pkt_valid && !pkt_ready.
- test_ending is high for exactly the cycle after the ENDING→ENDED edge. test_has_ended rises on the same edge.
- Reset mid-operation: all state is cleared on the next edge, including a held packet (pkt_valid drops without handshake), overflow, and test_has_ended.

## Test plan
- Partial flush:
  - Stimulus: trc_on=1, pkt_ready=1; codes 1,2,3 on consecutive cycles, then flush_req.
  - Required: pkt_data=0x0000001B, pkt_count=3, pkt_valid high 1 cycle; dct_count returns to 0.
- Auto-packet:
  - Stimulus: 16 consecutive codes of 2'b10 with pkt_ready=1.
  - Required: pkt_data=0x2AAAAAAA, pkt_count=15; the 16th code leaves dct_count=1, dct_buffer=0x2; overflow=0.
- Backpressure and overflow:
  - Stimulus: pkt_ready=0; 31 codes of 2'b01.
  - Required: first packet held with pkt_count=15; accumulator count=15, buffer=0x15555555; 31st code dropped and overflow=1.
  - Then raise pkt_ready: second packet emitted the next cycle.
- End sequence:
  - Stimulus: 5 codes of 2'b11, then end_req with pkt_ready=1; in_valid held high afterwards.
  - Required: packet pkt_count=5, pkt_data=0x3FF; test_ending pulses exactly once; test_has_ended stays 1; dct_count stays 0.
- Trace disabled: trc_on=0 with 10 valid codes → dct_count=0, overflow=0, pkt_valid=0.
- Mid-operation reset:
  - Stimulus: pkt_valid=1 with pkt_ready=0, dct_count=7, overflow=1; assert reset for 1 cycle.
  - Required: every output is 0 on the next cycle; a subsequent code gives dct_count=1.
